// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory responder.
// Covers the FSM state encoding, word width, latency counter width and access error check.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  // A word access is illegal when the byte address is not word aligned or the word index is past the end.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    logic [31:0] depth_w;
    word_idx = {2'b00, addr[31:2]};
    depth_w  = depth;
    return (addr[1:0] != 2'b00) || (word_idx >= depth_w);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed data storage.
// Writes are synchronous and reads are asynchronous.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int    DEPTH     = 16384,
  parameter string INIT_FILE = "",
  localparam int   IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port.
// Accepts one request at a time, waits LATENCY cycles, then performs the access and holds the response until it is taken.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int    LATENCY   = 4,
  parameter int    DEPTH     = 16384,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;

  logic              mem_we;
  logic              access_err;
  logic [WORD_W-1:0] mem_rdata;

  data_mem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    mem_we       = 1'b0;
    access_err   = addr_err(addr_q, DEPTH);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d        = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          count_d     = CNT_W'(LATENCY - 1);
          state_d     = BUSY;
          req_ready_d = 1'b0;
        end
      end
      BUSY: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          // The access happens on the edge that leaves BUSY, so a load sees any earlier store.
          mem_we       = wr_q && !access_err;
          rdata_d      = (wr_q || access_err) ? '0 : mem_rdata;
          err_d        = access_err;
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        req_valid_1, req_ready_1, req_write_1, resp_valid_1, resp_ready_1, resp_err_1;
  logic [31:0] req_addr_1, req_wdata_1, resp_rdata_1;

  data_mem_responder #(.LATENCY(4), .DEPTH(DEPTH), .INIT_FILE("")) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.LATENCY(1), .DEPTH(DEPTH), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
    .resp_rdata(resp_rdata_1), .resp_err(resp_err_1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
    @(negedge clk);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic collect(input int acc, input int hold, output logic [31:0] rd, output logic e, output int lat);
    lat = -1;
    rd  = '0;
    e   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = cyc - acc;
        rd  = resp_rdata;
        e   = resp_err;
        break;
      end
    end
    if (lat >= 0) begin
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    int acc;
    issue(w, a, d, acc);
    collect(acc, 0, rd, e, lat);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    req_valid_1 = 0; req_write_1 = 0; req_addr_1 = 0; req_wdata_1 = 0; resp_ready_1 = 1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    vectors++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_resp_data: got %h/%b expected 0/0", resp_rdata, resp_err);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic e; int lat; exp_t x;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    txn(1'b1, 32'h40, 32'h1234_5678, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL store_latency: got %0d expected 4", lat); end
    vectors++;
    if (rd !== x.rdata || e !== x.err) begin miscompares++; $display("FAIL store_resp: got %h/%b expected %h/%b", rd, e, x.rdata, x.err); end
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    txn(1'b0, 32'h40, 32'h0, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL load_latency: got %0d expected 4", lat); end
    vectors++;
    if (rd !== x.rdata || e !== x.err) begin miscompares++; $display("FAIL load_resp: got %h/%b expected %h/%b", rd, e, x.rdata, x.err); end
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] rd; logic e; int lat; int acc; exp_t x;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    txn(1'b1, 32'h10, 32'hCAFE_F00D, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (rd !== x.rdata || e !== x.err || lat !== 4) begin
      miscompares++; $display("FAIL pre_store: got %h/%b lat %0d expected %h/%b lat 4", rd, e, lat, x.rdata, x.err);
    end
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, acc);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL midbusy_reset_valid: got %b expected 0", resp_valid); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL midbusy_release: got ready %b valid %b expected 1 0", req_ready, resp_valid);
    end
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    txn(1'b0, 32'h10, 32'h0, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (rd !== x.rdata || e !== x.err) begin miscompares++; $display("FAIL dropped_store: got %h/%b expected %h/%b", rd, e, x.rdata, x.err); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat; exp_t x;
    logic        w_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t [4] = '{(DEPTH-1)*4, 32'h42, DEPTH*4, (DEPTH-1)*4};
    logic [31:0] d_t [4] = '{32'hA5A5_5A5A, 32'h0, 32'hFFFF_FFFF, 32'h0};
    exp_t        e_t [4] = '{'{32'h0, 1'b0}, '{32'h0, 1'b1}, '{32'h0, 1'b1}, '{32'hA5A5_5A5A, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(e_t[i]);
      txn(w_t[i], a_t[i], d_t[i], rd, e, lat);
      x = sb.pop_front();
      vectors++;
      if (rd !== x.rdata || e !== x.err || lat !== 4) begin
        miscompares++; $display("FAIL err_case%0d: got %h/%b lat %0d expected %h/%b lat 4", i, rd, e, lat, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic e; int lat; int acc; exp_t x;
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    issue(1'b0, 32'h40, 32'h0, acc);
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = cyc - acc; break; end
    end
    x = sb.pop_front();
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== x.rdata || resp_err !== x.err || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v%b %h/%b r%b expected v1 %h/%b r0", i, resp_valid, resp_rdata, resp_err, req_ready, x.rdata, x.err);
      end
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'b1;
      req_addr  = 32'h40;
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", resp_valid, req_ready);
    end
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    txn(1'b0, 32'h40, 32'h0, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (rd !== x.rdata || e !== x.err) begin miscompares++; $display("FAIL bp_no_effect: got %h/%b expected %h/%b", rd, e, x.rdata, x.err); end
  endtask

  task automatic test_capture;
    logic [31:0] rd; logic e; int lat; int acc; exp_t x;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    txn(1'b1, 32'h84, 32'h1111_1111, rd, e, lat);
    x = sb.pop_front();
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h80, 32'h2222_2222, acc);
    req_addr  = 32'h84;
    req_wdata = 32'h3333_3333;
    req_write = 1'b1;
    collect(acc, 0, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (rd !== x.rdata || e !== x.err || lat !== 4) begin
      miscompares++; $display("FAIL capture_store: got %h/%b lat %0d expected %h/%b lat 4", rd, e, lat, x.rdata, x.err);
    end
    sb.push_back('{rdata: 32'h2222_2222, err: 1'b0});
    sb.push_back('{rdata: 32'h1111_1111, err: 1'b0});
    txn(1'b0, 32'h80, 32'h0, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (rd !== x.rdata || e !== x.err) begin miscompares++; $display("FAIL capture_addr80: got %h/%b expected %h/%b", rd, e, x.rdata, x.err); end
    txn(1'b0, 32'h84, 32'h0, rd, e, lat);
    x = sb.pop_front();
    vectors++;
    if (rd !== x.rdata || e !== x.err) begin miscompares++; $display("FAIL capture_addr84: got %h/%b expected %h/%b", rd, e, x.rdata, x.err); end
  endtask

  task automatic test_back_to_back;
    logic        w_t [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] a_t [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'h0, 32'h8, 32'h4};
    logic [31:0] d_t [8] = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] r_t [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4000_0004, 32'h1000_0001, 32'h3000_0003, 32'h2000_0002};
    int accs[$];
    int idx = 0;
    int nresp = 0;
    int prev_acc = -1;
    int a0;
    logic acc_now;
    exp_t x;
    @(negedge clk);
    req_write_1 = w_t[0]; req_addr_1 = a_t[0]; req_wdata_1 = d_t[0]; req_valid_1 = 1'b1;
    for (int c = 0; c < 80 && nresp < 8; c++) begin
      if (resp_valid_1) begin
        x  = sb.pop_front();
        a0 = accs.pop_front();
        vectors++;
        if (resp_rdata_1 !== x.rdata || resp_err_1 !== x.err || (cyc - a0) !== 1) begin
          miscompares++;
          $display("FAIL b2b_resp%0d: got %h/%b lat %0d expected %h/%b lat 1", nresp, resp_rdata_1, resp_err_1, cyc - a0, x.rdata, x.err);
        end
        nresp++;
      end
      acc_now = req_valid_1 && req_ready_1;
      @(posedge clk);
      #1;
      if (acc_now) begin
        sb.push_back('{rdata: r_t[idx], err: 1'b0});
        accs.push_back(cyc);
        if (prev_acc >= 0) begin
          vectors++;
          if ((cyc - prev_acc) !== 3) begin
            miscompares++; $display("FAIL b2b_interval%0d: got %0d expected 3", idx, cyc - prev_acc);
          end
        end
        prev_acc = cyc;
        idx++;
        if (idx < 8) begin
          req_write_1 = w_t[idx]; req_addr_1 = a_t[idx]; req_wdata_1 = d_t[idx];
        end else begin
          req_valid_1 = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid_1 = 1'b0;
    vectors++;
    if (nresp !== 8) begin miscompares++; $display("FAIL b2b_count: got %0d expected 8", nresp); end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_reset_mid_busy;
    test_errors;
    test_backpressure;
    test_capture;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
